spi_frame_master: RTL
=====================

# spi_frame_master

Synthesizable SPI initiator that generates the same register-access frame the slot-controller SPI slave decodes: 8-bit address, 6 dummy clocks, 16-bit data, MSB first, SCLK idle low, MOSI sampled by the slave on SCLK rising edge. It sits on the system board between a local request/response port and the `spi0_*` pins of a slot FPGA. It captures the slave's MISO echo: the address during the address phase, and the previously written data during the data phase. A response is returned once per frame.

## Interface
- `ADDR_W`, 8, address bits per frame
- `DATA_W`, 16, data bits per frame
- `DUMMY_CYCLES`, 6, SCLK cycles between address and data; MOSI held 0
- `HALF_DIV`, 2, sys_clk cycles per SCLK half period (≥1)
- `CS_GAP`, 3, sys_clk cycles CS stays high after a frame before the next accept (≥1)
- `sys_clk`  in  1  system clock; all logic on rising edge
- `sys_rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_addr`  in  ADDR_W  address to shift out
- `req_data`  in  DATA_W  data to shift out
- `rsp_valid`  out  1  one-cycle pulse, response fields valid
- `rsp_addr`  out  ADDR_W  MISO bits captured in the address phase
- `rsp_data`  out  DATA_W  MISO bits captured in the data phase
- `busy`  out  1  high from accept until the end of the gap
- `spi_clk`  out  1  SCLK, idle 0
- `spi_mosi`  out  1  serial data out, idle 0
- `spi_miso`  in  1  serial data in
- `spi_cs_n`  out  1  chip select, active low, idle 1

## Operation
- States: IDLE → SHIFT → TAIL → GAP → IDLE.
- IDLE: `req_ready`=1. A request is accepted when `req_valid`&&`req_ready`. Address and data are latched into a shift register of ADDR_W+DUMMY_CYCLES+DATA_W bits, with the dummy field set to 0.
- SHIFT: N = ADDR_W+DUMMY_CYCLES+DATA_W bits (default 30). Each bit has HALF_DIV cycles with SCLK low, then HALF_DIV cycles with SCLK high.
  - MOSI is updated at the start of each low phase.
  - On the cycle SCLK returns low, `spi_miso` is sampled into the capture register.
  - The bit counter decrements on each falling edge. SHIFT exits after bit N's falling edge.
- TAIL: HALF_DIV cycles with CS low and SCLK low. On exit:
  - `spi_cs_n`←1 and `spi_mosi`←0.
  - `rsp_valid` pulses for 1 cycle.
  - `rsp_addr`/`rsp_data` are loaded. Dummy-phase samples are discarded.
- GAP: CS_GAP cycles, then IDLE.
- `rsp_addr`/`rsp_data` hold their values until the next response.
- `req_*` is ignored outside IDLE. No queueing.
- Reset mid-frame aborts the frame. No `rsp_valid` is issued, and the slave sees CS rise with a partial frame.

## Timing
- Reset values:
  - `spi_cs_n`=1; `spi_clk`=0; `spi_mosi`=0.
  - `req_ready`=1 in the first cycle after reset is released; `busy`=0.
  - `rsp_valid`=0; `rsp_addr`=0; `rsp_data`=0.
- Accept at cycle 0. At cycle 1: `spi_cs_n`=0, `spi_mosi`=addr[ADDR_W-1], `req_ready`=0, `busy`=1.
- The first SCLK rise is at cycle 1+HALF_DIV.
- CS-low duration = N·2·HALF_DIV + HALF_DIV cycles (122 at defaults).
- `rsp_valid` is asserted in the same cycle that `spi_cs_n` returns to 1.
- `req_ready` returns CS_GAP cycles after `rsp_valid`.
- Back-to-back accept-to-accept period = 1 + N·2·HALF_DIV + HALF_DIV + CS_GAP (126 at defaults).
- All SPI outputs are registered. `spi_miso` is sampled directly, so the slave must settle it within a half period.

## Configuration
- `SPI_FRAME_MASTER_ECHO_CHECK_EN` defined:
  - Adds output `rsp_addr_err` (1 bit, reset 0).
  - It is updated with `rsp_valid`: 1 when the captured `rsp_addr` ≠ the latched `req_addr`, else 0.
  - It holds its value until the next response.
- Undefined: the port and compare logic are absent.

## Structure
- Shared package `spi_frame_pkg`:
  - state enum;
  - default constants ADDR_W=8, DATA_W=16, DUMMY_CYCLES=6;
  - derived FRAME_BITS.
- The slot-slave model uses the same package.
- One natural sub-module: `spi_sclk_gen`, the half-period divider. It emits `rise` and `fall` strobes and idles low when not enabled. All other logic stays in the top module.

## Test plan
- Reset, then idle 10 cycles → `spi_cs_n`=1, `spi_clk`=0, `spi_mosi`=0, `req_ready`=1, no `rsp_valid`.
- Request addr 0x00, data 0xFFFF against the slave model, with MOSI and frame checking:
  - slave decodes addr 0x00 and data 0xFFFF;
  - exactly 30 SCLK rises;
  - CS low for 122 cycles;
  - MOSI is 0 during all 6 dummy clocks.
- Write 0x02/0xAAAA, then 0x02/0x0000 → second response has `rsp_addr`=0x02, `rsp_data`=0xAAAA.
- Hold `req_valid` high continuously with 3 requests → accepts are 126 cycles apart. Each frame produces exactly one `rsp_valid` pulse. Requests presented during a busy period are not taken.
- Assert `sys_rst` at SCLK rise 12 of a frame → next cycle `spi_cs_n`=1, `spi_clk`=0. No `rsp_valid`. A following 0x01/0x5555 frame completes correctly.
- With `SPI_FRAME_MASTER_ECHO_CHECK_EN` and a slave model that corrupts the echo to 0x03 on a request to 0x01 → `rsp_addr_err`=1. The next clean frame → 0.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared types and default frame geometry for the SPI register-access frame
// (address, dummy clocks, data), used by the initiator and the slot-slave model.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StTail,
        StGap
    } state_e;

    localparam int unsigned SPI_ADDR_W       = 8;
    localparam int unsigned SPI_DATA_W       = 16;
    localparam int unsigned SPI_DUMMY_CYCLES = 6;
    localparam int unsigned SPI_FRAME_BITS   = SPI_ADDR_W + SPI_DUMMY_CYCLES + SPI_DATA_W;

    function automatic int unsigned frame_bits(input int unsigned addr_w,
                                               input int unsigned dummy_cycles,
                                               input int unsigned data_w);
        return addr_w + dummy_cycles + data_w;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: HALF_DIV cycles low, HALF_DIV cycles high while enabled.
// rise_o/fall_o flag the cycle whose closing edge makes SCLK go high/low.
module spi_sclk_gen #(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HALF_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            sclk_q;
    logic            wrap;

    assign wrap   = en_i && (cnt_q == CntMax);
    assign rise_o = wrap && !sclk_q;
    assign fall_o = wrap && sclk_q;
    assign sclk_o = sclk_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (wrap) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI initiator for the slot-controller register frame: addr, dummy clocks, data, MSB first.
// Optional echo check of the captured address is enabled by SPI_FRAME_MASTER_ECHO_CHECK_EN.
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int unsigned ADDR_W       = SPI_ADDR_W,
    parameter int unsigned DATA_W       = SPI_DATA_W,
    parameter int unsigned DUMMY_CYCLES = SPI_DUMMY_CYCLES,
    parameter int unsigned HALF_DIV     = 2,
    parameter int unsigned CS_GAP       = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
`ifdef SPI_FRAME_MASTER_ECHO_CHECK_EN
    output logic              rsp_addr_err,
`endif
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    localparam int unsigned N       = frame_bits(ADDR_W, DUMMY_CYCLES, DATA_W);
    localparam int unsigned CapW    = ADDR_W + DATA_W;
    localparam int unsigned BitCntW = $clog2(N + 1);
    localparam int unsigned WaitMax = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
    localparam int unsigned WaitW   = $clog2(WaitMax + 1);

    localparam logic [BitCntW-1:0] BitsTotal = BitCntW'(N);
    localparam logic [BitCntW-1:0] DummyHi   = BitCntW'(DATA_W + DUMMY_CYCLES);
    localparam logic [BitCntW-1:0] DummyLo   = BitCntW'(DATA_W);
    localparam logic [BitCntW-1:0] LastBit   = BitCntW'(1);
    localparam logic [WaitW-1:0]   TailLoad  = WaitW'(HALF_DIV - 1);
    localparam logic [WaitW-1:0]   GapLoad   = WaitW'(CS_GAP - 1);

    state_e              state_q;
    logic [N-2:0]        sr_q;
    logic [CapW-1:0]     cap_q;
    logic                cap_en_q;
    logic [BitCntW-1:0]  bit_cnt_q;
    logic [WaitW-1:0]    wait_q;
    logic                cs_n_q;
    logic                mosi_q;
    logic                req_ready_q;
    logic                busy_q;
    logic                rsp_valid_q;
    logic [ADDR_W-1:0]   rsp_addr_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [N-1:0]        frame;
    logic                sclk_rise;
    logic                sclk_fall;
`ifdef SPI_FRAME_MASTER_ECHO_CHECK_EN
    logic [ADDR_W-1:0]   addr_q;
    logic                addr_err_q;
    assign rsp_addr_err = addr_err_q;
`endif

    assign frame = {req_addr, {DUMMY_CYCLES{1'b0}}, req_data};

    spi_sclk_gen #(
        .HALF_DIV(HALF_DIV)
    ) u_sclk_gen (
        .clk_i (sys_clk),
        .rst_i (sys_rst),
        .en_i  (state_q == StShift),
        .sclk_o(spi_clk),
        .rise_o(sclk_rise),
        .fall_o(sclk_fall)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            cap_q       <= '0;
            cap_en_q    <= 1'b0;
            bit_cnt_q   <= '0;
            wait_q      <= '0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
`ifdef SPI_FRAME_MASTER_ECHO_CHECK_EN
            addr_q      <= '0;
            addr_err_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= StShift;
                        sr_q        <= frame[N-2:0];
                        mosi_q      <= frame[N-1];
                        bit_cnt_q   <= BitsTotal;
                        cs_n_q      <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef SPI_FRAME_MASTER_ECHO_CHECK_EN
                        addr_q      <= req_addr;
`endif
                    end
                end
                StShift: begin
                    // Dummy-phase samples never enter the capture register.
                    if (sclk_rise) begin
                        cap_en_q <= (bit_cnt_q > DummyHi) || (bit_cnt_q <= DummyLo);
                    end
                    if (sclk_fall) begin
                        if (cap_en_q) begin
                            cap_q <= {cap_q[CapW-2:0], spi_miso};
                        end
                        mosi_q    <= sr_q[N-2];
                        sr_q      <= {sr_q[N-3:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            state_q <= StTail;
                            wait_q  <= TailLoad;
                        end
                    end
                end
                StTail: begin
                    if (wait_q == '0) begin
                        state_q     <= StGap;
                        wait_q      <= GapLoad;
                        cs_n_q      <= 1'b1;
                        mosi_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_addr_q  <= cap_q[CapW-1 -: ADDR_W];
                        rsp_data_q  <= cap_q[DATA_W-1:0];
`ifdef SPI_FRAME_MASTER_ECHO_CHECK_EN
                        addr_err_q  <= (cap_q[CapW-1 -: ADDR_W] != addr_q);
`endif
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StGap: begin
                    if (wait_q == '0) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs_n  = cs_n_q;

endmodule
